// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream FIFO slice.
//   - Default parameter values for the data, id and dest widths and depth.
//   - axis_beat_t: one stored beat laid out at the default widths. Modules
//     parameterised away from the defaults declare the same field order
//     locally so that packing stays identical.
//   - beatWidth(): packed width of one beat for arbitrary widths, used to
//     size the storage array.
// ---------------------------------------------------------------------------
package axis_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_ID_WIDTH   = 8;
    localparam int DEF_DEST_WIDTH = 4;

    // Field order here defines the bit layout of a stored entry, MSB first.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]   tdata;
        logic [DEF_ID_WIDTH-1:0]     tid;
        logic [DEF_DEST_WIDTH-1:0]   tdest;
        logic                        tlast;
        logic [DEF_DATA_WIDTH/8-1:0] tstrb;
        logic [DEF_DATA_WIDTH/8-1:0] tkeep;
    } axis_beat_t;

    // Packed width of one beat: tdata + tid + tdest + tlast + tstrb + tkeep.
    function automatic int beatWidth(input int dataWidth,
                                     input int idWidth,
                                     input int destWidth);
        return dataWidth + idWidth + destWidth + 1 + 2 * (dataWidth / 8);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// ---------------------------------------------------------------------------
// axis_fifo_ram
// DEPTH x WIDTH storage for the FIFO. One synchronous write port and one
// asynchronous read port. The array has no reset: the FIFO only presents a
// head entry when it knows that entry has been written.
// Ports:
//   i_clk     clock for the write port
//   i_wrEn    write strobe
//   i_wrAddr  write address
//   i_wrData  entry to store
//   i_rdAddr  read address (the FIFO head)
//   o_rdData  entry at i_rdAddr, combinational
// ---------------------------------------------------------------------------
module axis_fifo_ram #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_wrEn,
    input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]         i_wrData,
    input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
    output logic [WIDTH-1:0]         o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/axis_fifo.sv
// ---------------------------------------------------------------------------
// axis_fifo
// Synchronous AXI-Stream FIFO carrying tdata with tid, tdest, tlast, tstrb and
// tkeep as one entry. Beats leave in acceptance order; a beat accepted into
// an empty FIFO is presented one cycle later (no bypass). Both handshake
// outputs are registered, so there is no combinational path from
// m_axis_tready to s_axis_tready.
// DATA_WIDTH must be a multiple of 8, DEPTH a power of two >= 2,
// ID_WIDTH at most 8.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   s_axis_*            ingress stream (tdata/tid/tdest/tlast/tstrb/tkeep,
//                       tvalid in, tready out)
//   m_axis_*            egress stream (same fields, tvalid out, tready in)
//   count               beats currently stored
//   pkt_count           stored beats that carry tlast=1
// ---------------------------------------------------------------------------
module axis_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ID_WIDTH   = DEF_ID_WIDTH,
    parameter int DEST_WIDTH = DEF_DEST_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [ID_WIDTH-1:0]        s_axis_tid,
    input  logic [DEST_WIDTH-1:0]      s_axis_tdest,
    input  logic                       s_axis_tlast,
    input  logic [DATA_WIDTH/8-1:0]    s_axis_tstrb,
    input  logic [DATA_WIDTH/8-1:0]    s_axis_tkeep,

    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [ID_WIDTH-1:0]        m_axis_tid,
    output logic [DEST_WIDTH-1:0]      m_axis_tdest,
    output logic                       m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0]    m_axis_tstrb,
    output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,

    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] pkt_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int BEAT_W = beatWidth(DATA_WIDTH, ID_WIDTH, DEST_WIDTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Same field order as axis_pkg::axis_beat_t, at this instance's widths.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] tdata;
        logic [ID_WIDTH-1:0]   tid;
        logic [DEST_WIDTH-1:0] tdest;
        logic                  tlast;
        logic [KEEP_W-1:0]     tstrb;
        logic [KEEP_W-1:0]     tkeep;
    } beat_t;

    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_pktCount;
    logic             r_sReady;
    logic             r_mValid;

    logic             w_push;
    logic             w_pop;
    logic             w_pushLast;
    logic             w_popLast;
    logic [CNT_W-1:0] w_countNext;
    logic [CNT_W-1:0] w_pktNext;
    beat_t            w_wrBeat;
    beat_t            w_rdBeat;

    assign w_push     = s_axis_tvalid & r_sReady;
    assign w_pop      = r_mValid & m_axis_tready;
    assign w_pushLast = w_push & s_axis_tlast;
    assign w_popLast  = w_pop & w_rdBeat.tlast;

    assign w_wrBeat = '{tdata: s_axis_tdata, tid: s_axis_tid, tdest: s_axis_tdest,
                        tlast: s_axis_tlast, tstrb: s_axis_tstrb, tkeep: s_axis_tkeep};

    // Next occupancy and packet counts; a push and a pop on the same edge cancel.
    always_comb begin
        w_countNext = r_count;
        w_pktNext   = r_pktCount;
        if (w_push && !w_pop) begin
            w_countNext = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CNT_W'(1);
        end
        if (w_pushLast && !w_popLast) begin
            w_pktNext = r_pktCount + CNT_W'(1);
        end else if (!w_pushLast && w_popLast) begin
            w_pktNext = r_pktCount - CNT_W'(1);
        end
    end

    // Pointers, counts and handshake flags. The flags are computed from the
    // next count so they are registered yet exact in the following cycle.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_pktCount <= '0;
            r_sReady   <= 1'b0;
            r_mValid   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count    <= w_countNext;
            r_pktCount <= w_pktNext;
            r_sReady   <= (w_countNext != FULL_CNT);
            r_mValid   <= (w_countNext != '0);
        end
    end

    axis_fifo_ram #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk    (clk),
        .i_wrEn   (w_push),
        .i_wrAddr (r_wrPtr),
        .i_wrData (w_wrBeat),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_rdBeat)
    );

    assign s_axis_tready = r_sReady;
    assign m_axis_tvalid = r_mValid;
    assign m_axis_tdata  = w_rdBeat.tdata;
    assign m_axis_tid    = w_rdBeat.tid;
    assign m_axis_tdest  = w_rdBeat.tdest;
    assign m_axis_tlast  = w_rdBeat.tlast;
    assign m_axis_tstrb  = w_rdBeat.tstrb;
    assign m_axis_tkeep  = w_rdBeat.tkeep;
    assign count         = r_count;
    assign pkt_count     = r_pktCount;

endmodule

// File: tb/tb_axis_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo
// Directed self-checking bench for axis_fifo at its default parameters.
// Beats are packed as {tdata, tid, tdest, tlast, tstrb, tkeep} (23 bits);
// beatOf(i) builds a distinct beat from an index so order and sideband can
// be checked against an independently generated sequence.
// ---------------------------------------------------------------------------
module tb_axis_fifo;

    localparam int DW  = 8;
    localparam int IW  = 8;
    localparam int DSW = 4;
    localparam int KW  = 1;
    localparam int CW  = 5;
    localparam int BW  = DW + IW + DSW + 1 + 2 * KW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [IW-1:0] s_axis_tid;
    logic [DSW-1:0] s_axis_tdest;
    logic          s_axis_tlast;
    logic [KW-1:0] s_axis_tstrb;
    logic [KW-1:0] s_axis_tkeep;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [IW-1:0] m_axis_tid;
    logic [DSW-1:0] m_axis_tdest;
    logic          m_axis_tlast;
    logic [KW-1:0] m_axis_tstrb;
    logic [KW-1:0] m_axis_tkeep;
    logic [CW-1:0] count;
    logic [CW-1:0] pkt_count;
    logic [BW-1:0] mBeat;

    int checkCount = 0;
    int errorCount = 0;

    axis_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tkeep  (s_axis_tkeep),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tkeep  (m_axis_tkeep),
        .count         (count),
        .pkt_count     (pkt_count)
    );

    assign mBeat = {m_axis_tdata, m_axis_tid, m_axis_tdest, m_axis_tlast,
                    m_axis_tstrb, m_axis_tkeep};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives the ingress side with one packed beat.
    task automatic applyStimulus(input logic valid, input logic [BW-1:0] beat);
        s_axis_tvalid = valid;
        {s_axis_tdata, s_axis_tid, s_axis_tdest, s_axis_tlast,
         s_axis_tstrb, s_axis_tkeep} = beat;
    endtask

    // Advance one clock and settle just after the edge before sampling.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Distinct beat per index; tlast on every 4th beat, tkeep zero on even beats.
    function automatic logic [BW-1:0] beatOf(input int i);
        logic [7:0] d;
        d = 8'(i);
        return {d, d ^ 8'h5A, d[3:0] ^ 4'h9, (d[1:0] == 2'b11), d[2], d[0]};
    endfunction

    // Watchdog: the run is bounded well below this.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [BW-1:0] b;
        logic          accepted;
        logic          pushW;
        logic          popW;
        int            k;
        int            inIdx;
        int            outIdx;
        int            cycles;

        // ---------------- reset state ----------------
        rst = 1'b1;
        m_axis_tready = 1'b0;
        applyStimulus(1'b0, '0);
        tick;
        tick;
        checkOutput("reset count", 64'(count), 64'(0));
        checkOutput("reset pkt_count", 64'(pkt_count), 64'(0));
        checkOutput("reset s_tready", 64'(s_axis_tready), 64'(0));
        checkOutput("reset m_tvalid", 64'(m_axis_tvalid), 64'(0));
        rst = 1'b0;
        tick;
        checkOutput("ready after reset", 64'(s_axis_tready), 64'(1));

        // ---------------- single beat ----------------
        $display("[TB] single beat");
        m_axis_tready = 1'b1;
        b = {8'hA5, 8'd3, 4'd2, 1'b1, 1'b1, 1'b1};
        applyStimulus(1'b1, b);
        checkOutput("single pkt before", 64'(pkt_count), 64'(0));
        tick;
        applyStimulus(1'b0, b);
        checkOutput("single valid", 64'(m_axis_tvalid), 64'(1));
        checkOutput("single beat", 64'(mBeat), 64'(b));
        checkOutput("single pkt during", 64'(pkt_count), 64'(1));
        checkOutput("single count", 64'(count), 64'(1));
        tick;
        checkOutput("single valid after", 64'(m_axis_tvalid), 64'(0));
        checkOutput("single pkt after", 64'(pkt_count), 64'(0));
        checkOutput("single count after", 64'(count), 64'(0));
        m_axis_tready = 1'b0;

        // ---------------- fill to full ----------------
        $display("[TB] fill and full");
        k = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            applyStimulus(1'b1, beatOf(k));
            accepted = s_axis_tready;
            tick;
            if (accepted) k++;
        end
        checkOutput("full accepted", 64'(k), 64'(16));
        checkOutput("full count", 64'(count), 64'(16));
        checkOutput("full s_tready", 64'(s_axis_tready), 64'(0));
        checkOutput("full pkt_count", 64'(pkt_count), 64'(4));
        checkOutput("full head", 64'(mBeat), 64'(beatOf(0)));
        m_axis_tready = 1'b1;
        tick;
        m_axis_tready = 1'b0;
        checkOutput("ready after pop", 64'(s_axis_tready), 64'(1));
        checkOutput("count after pop", 64'(count), 64'(15));
        tick;
        applyStimulus(1'b0, '0);
        checkOutput("refull count", 64'(count), 64'(16));
        checkOutput("refull s_tready", 64'(s_axis_tready), 64'(0));
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            checkOutput("drain order", 64'(mBeat), 64'(beatOf(i)));
            tick;
        end
        m_axis_tready = 1'b0;
        checkOutput("drained count", 64'(count), 64'(0));
        checkOutput("drained valid", 64'(m_axis_tvalid), 64'(0));

        // ---------------- wrap and order, random throttling ----------------
        $display("[TB] random throttled order");
        inIdx  = 0;
        outIdx = 0;
        cycles = 0;
        while (outIdx < 40 && cycles < 3000) begin
            if (!s_axis_tvalid && inIdx < 40 && $urandom_range(1) == 1)
                applyStimulus(1'b1, beatOf(inIdx));
            m_axis_tready = 1'($urandom_range(1));
            pushW = s_axis_tvalid & s_axis_tready;
            popW  = m_axis_tvalid & m_axis_tready;
            if (popW) begin
                checkOutput("order beat", 64'(mBeat), 64'(beatOf(outIdx)));
                outIdx++;
            end
            tick;
            cycles++;
            if (pushW) begin
                inIdx++;
                applyStimulus(1'b0, '0);
            end
        end
        m_axis_tready = 1'b0;
        applyStimulus(1'b0, '0);
        checkOutput("order total", 64'(outIdx), 64'(40));
        checkOutput("order count", 64'(count), 64'(0));
        checkOutput("order pkt_count", 64'(pkt_count), 64'(0));

        // ---------------- concurrent at mid level ----------------
        $display("[TB] concurrent at count 8");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, beatOf(100 + i));
            tick;
        end
        applyStimulus(1'b0, '0);
        checkOutput("mid count", 64'(count), 64'(8));
        m_axis_tready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            applyStimulus(1'b1, beatOf(108 + j));
            checkOutput("concurrent head", 64'(mBeat), 64'(beatOf(100 + j)));
            checkOutput("concurrent ready", 64'({s_axis_tready, m_axis_tvalid}), 64'(3));
            tick;
            checkOutput("concurrent count", 64'(count), 64'(8));
        end
        applyStimulus(1'b0, '0);
        for (int j = 0; j < 8; j++) begin
            checkOutput("concurrent tail", 64'(mBeat), 64'(beatOf(120 + j)));
            tick;
        end
        m_axis_tready = 1'b0;
        checkOutput("concurrent empty", 64'(count), 64'(0));

        // ---------------- hold stability ----------------
        $display("[TB] hold stability");
        applyStimulus(1'b1, beatOf(8'h3C));
        tick;
        applyStimulus(1'b1, beatOf(8'h3D));
        tick;
        applyStimulus(1'b0, '0);
        for (int c = 0; c < 10; c++) begin
            checkOutput("hold valid", 64'(m_axis_tvalid), 64'(1));
            checkOutput("hold payload", 64'(mBeat), 64'(beatOf(8'h3C)));
            tick;
        end
        checkOutput("hold count", 64'(count), 64'(2));
        m_axis_tready = 1'b1;
        tick;
        tick;
        m_axis_tready = 1'b0;

        // ---------------- reset mid-packet ----------------
        $display("[TB] reset mid-packet");
        for (int i = 0; i < 5; i++) begin
            b = beatOf(8'h50 + i);
            b[2] = 1'b0;
            applyStimulus(1'b1, b);
            tick;
        end
        applyStimulus(1'b0, '0);
        checkOutput("pre-reset count", 64'(count), 64'(5));
        checkOutput("pre-reset pkt_count", 64'(pkt_count), 64'(0));
        rst = 1'b1;
        tick;
        checkOutput("mid-reset count", 64'(count), 64'(0));
        checkOutput("mid-reset pkt_count", 64'(pkt_count), 64'(0));
        checkOutput("mid-reset m_tvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("mid-reset s_tready", 64'(s_axis_tready), 64'(0));
        rst = 1'b0;
        tick;
        checkOutput("post-reset s_tready", 64'(s_axis_tready), 64'(1));
        checkOutput("post-reset m_tvalid", 64'(m_axis_tvalid), 64'(0));
        b = {8'h11, 8'h01, 4'h1, 1'b1, 1'b1, 1'b1};
        applyStimulus(1'b1, b);
        tick;
        applyStimulus(1'b0, '0);
        checkOutput("first after reset valid", 64'(m_axis_tvalid), 64'(1));
        checkOutput("first after reset beat", 64'(mBeat), 64'(b));
        m_axis_tready = 1'b1;
        tick;
        checkOutput("after reset drained", 64'(m_axis_tvalid), 64'(0));
        m_axis_tready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
